uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Shares one `uart_tx` serializer among `NUM_REQ` byte-stream requesters. Round-robin arbitration runs per frame: a requester that presents a multi-byte frame, delimited by `req_last`, keeps the transmitter until its last byte completes. The block sits between the requesters and `uart_tx` and drives that block's `tx_start`/`tx_data` handshake. It waits for `tx_done` before issuing the next byte.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `GAP_CYCLES`, default 0: idle clocks inserted after each `tx_done`, 0..255.
- `LOCK_TIMEOUT`, default 1024: clocks a locked owner may leave `req_valid` low before its lock is dropped. 0 disables the timeout.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  NUM_REQ  requester i has a byte.
- `req_data`  in  8*NUM_REQ  byte of requester i at `[8i+7:8i]`.
- `req_last`  in  NUM_REQ  byte of requester i ends its frame.
- `req_ready`  out  NUM_REQ  byte of requester i is accepted this cycle.
- `tx_start`  out  1  one-cycle start pulse to `uart_tx`.
- `tx_data`  out  8  byte to `uart_tx`; held stable from START until `tx_done`.
- `tx_done`  in  1  one-cycle pulse from `uart_tx` at end of stop bit.
- `grant`  out  NUM_REQ  one-hot current owner; 0 when no owner.
- `busy`  out  1  a byte is in flight or the gap is running.
- `lock_abort`  out  1  one-cycle pulse when the lock timeout drops an owner.

## Operation
- The FSM has four states: ARB, START, WAIT, GAP. Reset enters ARB.
- **ARB, unlocked:** the winner is the first asserted `req_valid` scanning from `rr_ptr` upward, modulo `NUM_REQ`.
- **ARB, locked:** only the owner is eligible.
- **Accept:** in ARB with an eligible valid, `req_ready[w]=1` combinationally in the same cycle. `req_data[w]` is registered into `tx_data`, `grant` becomes one-hot w, and the FSM goes to START.
- **Lock update on accept:**
  - `req_last[w]=0` sets `lock=1` and makes w the owner.
  - `req_last[w]=1` clears `lock` and sets `rr_ptr = (w+1) mod NUM_REQ`.
- **START:** `tx_start=1` for exactly one cycle, then the FSM goes to WAIT.
- **WAIT:** hold until `tx_done=1`. The FSM then goes to GAP if `GAP_CYCLES>0`, else to ARB.
- **GAP:** counts `GAP_CYCLES` clocks, then goes to ARB.
- **`grant` clearing:** on return to ARB with `lock=0`, `grant` clears. With `lock=1`, `grant` stays on the owner.
- **Lock timeout:** a counter runs in ARB while `lock=1` and the owner's `req_valid=0`. When it reaches `LOCK_TIMEOUT`:
  - `lock` clears and `grant` clears;
  - `rr_ptr` advances past the owner;
  - `lock_abort` pulses for one cycle.
  - The counter clears on any accept.
- **Ignored inputs:** `tx_done` outside WAIT is ignored. Non-granted requesters never see `req_ready`, and their `req_valid` may stay high indefinitely.
- **Single-requester case:** a lone requester is served back-to-back.
- **Fairness:** with all requesters valid and single-byte frames, grants rotate 0,1,2,3,0,…

## Timing
- **Reset values:** `req_ready=0`, `tx_start=0`, `tx_data=8'h00`, `grant=0`, `busy=0`, `lock_abort=0`, `lock=0`, `rr_ptr=0`, counters 0.
- **Reset mid-operation:** the same values are applied on the next edge. `uart_tx` shares `reset`, so no stray `tx_done` is expected afterwards.
- **Accept to start:** accept at cycle T, then `tx_start` at T+1 with `tx_data` already valid.
- **Done to next accept:** `tx_done` at cycle D, then the earliest next `req_ready` is at D+1+`GAP_CYCLES`.
- **`busy`:** 1 in START, WAIT and GAP; 0 in ARB.
- **Throughput:** at most one byte accepted per `tx_done` period.

## Structure
- Shared package `uart_pkg` holds:
  - the state enum for ARB, START, WAIT and GAP;
  - `UART_DATA_W = 8`.
- Sub-module `uart_rr_pick` is a combinational round-robin picker. Inputs are `req` and `ptr`; outputs are a one-hot `pick` and a `found` flag. It is instantiated once.
- The FSM, lock logic, timeout counter and gap counter live in the top module.

## Test plan
- **Single byte:** reset, then requester 2 sends `8'hA5` with `last=1`. Expect `req_ready[2]` for one cycle, `tx_start` one cycle later with `tx_data=A5`, and the paired `uart_rx` receives `A5`.
- **Round-robin:** all 4 requesters valid with `last=1`, data `10/11/12/13`. Expect transmit order 0,1,2,3, then 0 again when it is re-presented. `tx_start` never fires while `busy`.
- **Frame lock:** requester 1 sends `C0,C1,C2` with `last` on `C2`, while requester 0 stays valid throughout. Expect `C0 C1 C2` to go out contiguously, then requester 0's byte.
- **Gap:** `GAP_CYCLES=5`, two back-to-back bytes. Expect the second `req_ready` exactly 6 cycles after the first `tx_done`.
- **Lock timeout:** `LOCK_TIMEOUT=16`. Requester 3 sends `last=0`, then drops valid. Expect `lock_abort` 16 cycles after entering ARB, `grant=0`, and requester 0 served next.
- **Mid-operation reset:** assert `reset` during WAIT. Expect all outputs at reset values the next cycle, and a new byte then transmits normally.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types for the UART transmit arbiter: FSM state encoding, data width
// and the round-robin pointer increment.
package uart_pkg;

    localparam int UART_DATA_W = 8;

    typedef enum logic [1:0] {
        ST_ARB,
        ST_START,
        ST_WAIT,
        ST_GAP
    } arb_state_t;

    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Round-robin picker: one-hot first set bit of req scanning upward from ptr, wrapping.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides whether the pick is consumed.
module uart_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] pick,
    output logic               found
);

    // The first pass covers ptr..NUM_REQ-1 and the second wraps to 0..ptr-1.
    // Indices at or above ptr are already known clear by the time the second pass runs.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req[i] && (i >= int'(ptr))) begin
                pick[i] = 1'b1;
                found   = 1'b1;
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req[i]) begin
                pick[i] = 1'b1;
                found   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Frame-level round-robin arbiter sharing one uart_tx among NUM_REQ byte streams.
// Latency: accept at T, tx_start at T+1; next accept no earlier than tx_done+1+GAP_CYCLES.
// Backpressure: req_ready only in ARB to the single eligible winner; a locked frame owner excludes others.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int GAP_CYCLES   = 0,
    parameter int LOCK_TIMEOUT = 1024
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [UART_DATA_W*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]             req_last,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic                           tx_start,
    output logic [UART_DATA_W-1:0]         tx_data,
    input  logic                           tx_done,
    output logic [NUM_REQ-1:0]             grant,
    output logic                           busy,
    output logic                           lock_abort
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TMO_W = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT + 1) : 1;

    arb_state_t             state, state_nxt;
    logic                   lock;
    logic [PTR_W-1:0]       owner, rr_ptr, w_idx;
    logic [NUM_REQ-1:0]     eligible, pick;
    logic                   found, accept, owner_valid, tmo_hit, gap_end, to_arb;
    logic [TMO_W-1:0]       tmo_cnt;
    logic [7:0]             gap_cnt;
    logic [UART_DATA_W-1:0] sel_data;

    // While locked, grant is the one-hot owner, so it doubles as the eligibility mask.
    assign owner_valid = |(req_valid & grant);
    assign eligible    = lock ? (req_valid & grant) : req_valid;
    assign accept      = (state == ST_ARB) && found && !reset;
    assign req_ready   = accept ? pick : '0;
    assign gap_end     = (gap_cnt == 8'(GAP_CYCLES - 1));
    assign tmo_hit     = (LOCK_TIMEOUT != 0) && (state == ST_ARB) && lock && !owner_valid
                         && (tmo_cnt == TMO_W'(LOCK_TIMEOUT - 1));
    assign to_arb      = (state != ST_ARB) && (state_nxt == ST_ARB);

    uart_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_pick (
        .req   (eligible),
        .ptr   (rr_ptr),
        .pick  (pick),
        .found (found)
    );

    always_comb begin
        w_idx    = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick[i]) begin
                w_idx    = PTR_W'(i);
                sel_data = req_data[i*UART_DATA_W +: UART_DATA_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= ST_ARB;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b1;
        tx_start  = 1'b0;
        case (state)
            ST_ARB: begin
                busy = 1'b0;
                if (accept) state_nxt = ST_START;
            end
            ST_START: begin
                tx_start  = 1'b1;
                state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (tx_done) state_nxt = (GAP_CYCLES > 0) ? ST_GAP : ST_ARB;
            end
            ST_GAP: begin
                if (gap_end) state_nxt = ST_ARB;
            end
            default: state_nxt = ST_ARB;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_data    <= '0;
            grant      <= '0;
            lock       <= 1'b0;
            owner      <= '0;
            rr_ptr     <= '0;
            tmo_cnt    <= '0;
            gap_cnt    <= '0;
            lock_abort <= 1'b0;
        end else begin
            lock_abort <= 1'b0;
            if (accept) begin
                tx_data <= sel_data;
                grant   <= pick;
                tmo_cnt <= '0;
                if (|(req_last & pick)) begin
                    lock   <= 1'b0;
                    rr_ptr <= PTR_W'(rr_next(int'(w_idx), NUM_REQ));
                end else begin
                    lock  <= 1'b1;
                    owner <= w_idx;
                end
            end else if (tmo_hit) begin
                // Owner went silent mid-frame: release it and move the pointer past it.
                lock       <= 1'b0;
                grant      <= '0;
                tmo_cnt    <= '0;
                rr_ptr     <= PTR_W'(rr_next(int'(owner), NUM_REQ));
                lock_abort <= 1'b1;
            end else if ((LOCK_TIMEOUT != 0) && (state == ST_ARB) && lock && !owner_valid) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end

            if (to_arb && !lock) grant <= '0;

            if (state == ST_GAP) gap_cnt <= gap_end ? 8'd0 : gap_cnt + 8'd1;
            else                 gap_cnt <= 8'd0;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: queue-driven requesters, a uart_tx stand-in with random
// frame length, and a frame-level round-robin reference model.
module tb_uart_tx_arbiter;

    localparam int GAP = 5;
    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  req_valid = '0, req_last = '0, req_ready, grant;
    logic [31:0] req_data = '0;
    logic        tx_start, busy, lock_abort;
    logic        tx_done = 1'b0;
    logic [7:0]  tx_data;

    uart_tx_arbiter #(
        .NUM_REQ      (4),
        .GAP_CYCLES   (GAP),
        .LOCK_TIMEOUT (TMO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_last   (req_last),
        .req_ready  (req_ready),
        .tx_start   (tx_start),
        .tx_data    (tx_data),
        .tx_done    (tx_done),
        .grant      (grant),
        .busy       (busy),
        .lock_abort (lock_abort)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         c;
        int         r;
        logic [7:0] d;
        logic [3:0] g;
    } ev_t;

    logic [8:0] rq[4][$];   // bytes the requesters still present, {last, data}
    logic [8:0] mq[4][$];   // same content, consumed by the reference model
    ev_t        acc_q[$], st_q[$], exp_q[$];
    int         done_q[$], abort_q[$];
    logic [3:0] abort_grant;
    int         cyc, vectors, errors;
    bit         tx_act;
    int         tx_cnt;
    logic [7:0] tx_hold;
    int         overlap_n, unstable_n, badrdy_n;

    function automatic bit pending();
        for (int i = 0; i < 4; i++) if (rq[i].size() > 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic load(input int r, input logic l, input logic [7:0] d);
        rq[r].push_back({l, d});
        mq[r].push_back({l, d});
    endtask

    // One clock: drive inputs at +1 after the edge, sample outputs at +2.
    task automatic cycle();
        logic [8:0] h;
        ev_t        e;
        @(posedge clk);
        #1;
        cyc++;
        tx_done = 1'b0;
        if (tx_act) begin
            if (tx_cnt == 0) begin
                tx_done = 1'b1;
                tx_act  = 1'b0;
                done_q.push_back(cyc);
            end else begin
                tx_cnt--;
            end
        end
        for (int i = 0; i < 4; i++) begin
            h = (rq[i].size() > 0) ? rq[i][0] : 9'h0;
            req_valid[i]        = rq[i].size() > 0;
            req_last[i]         = h[8];
            req_data[i*8 +: 8]  = h[7:0];
        end
        #1;
        if (req_ready != 4'b0) begin
            if ($countones(req_ready) != 1) badrdy_n++;
            for (int i = 0; i < 4; i++) begin
                if (req_ready[i]) begin
                    if (!req_valid[i]) begin
                        badrdy_n++;
                    end else begin
                        h = rq[i].pop_front();
                        e.c = cyc; e.r = i; e.d = h[7:0]; e.g = 4'b0;
                        acc_q.push_back(e);
                    end
                end
            end
        end
        if (tx_start) begin
            if (tx_act) overlap_n++;
            e.c = cyc; e.r = 0; e.d = tx_data; e.g = grant;
            st_q.push_back(e);
            tx_act  = 1'b1;
            tx_hold = tx_data;
            tx_cnt  = $urandom_range(2, 8);
        end else if (tx_act && tx_data !== tx_hold) begin
            unstable_n++;
        end
        if (lock_abort) begin
            abort_q.push_back(cyc);
            abort_grant = grant;
        end
    endtask

    task automatic clear_log();
        acc_q.delete(); st_q.delete(); exp_q.delete(); done_q.delete(); abort_q.delete();
        overlap_n = 0; unstable_n = 0; badrdy_n = 0;
    endtask

    task automatic do_reset();
        for (int i = 0; i < 4; i++) begin rq[i].delete(); mq[i].delete(); end
        tx_act = 1'b0;
        reset  = 1'b1;
        cycle();
        cycle();
        reset = 1'b0;
        clear_log();
    endtask

    task automatic drain();
        int n = 0;
        do begin
            cycle();
            n++;
        end while ((busy || tx_act || pending() || (req_ready != 4'b0)) && n < 3000);
        vectors++;
        if (busy || tx_act || pending()) begin
            errors++;
            $display("FAIL drain: still active after %0d cycles, required idle", n);
        end
    endtask

    // Reference: whole frames in round-robin order, pointer moving past each finished frame.
    task automatic build_expect();
        int         ptr = 0;
        int         w;
        logic [8:0] b;
        ev_t        e;
        exp_q.delete();
        forever begin
            w = -1;
            for (int k = 0; k < 4; k++) if (w < 0 && mq[(ptr + k) % 4].size() > 0) w = (ptr + k) % 4;
            if (w < 0) break;
            do begin
                b = mq[w].pop_front();
                e.c = 0; e.r = w; e.d = b[7:0]; e.g = 4'b0;
                exp_q.push_back(e);
            end while (!b[8] && mq[w].size() > 0);
            ptr = (w + 1) % 4;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cycle();
        cycle();
        vectors++; if (req_ready !== 4'b0) begin errors++; $display("FAIL reset_ready: got %b, want 0000", req_ready); end
        vectors++; if (tx_start !== 1'b0) begin errors++; $display("FAIL reset_start: got %b, want 0", tx_start); end
        vectors++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h, want 00", tx_data); end
        vectors++; if (grant !== 4'b0) begin errors++; $display("FAIL reset_grant: got %b, want 0000", grant); end
        vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, want 0", busy); end
        vectors++; if (lock_abort !== 1'b0) begin errors++; $display("FAIL reset_abort: got %b, want 0", lock_abort); end
        reset = 1'b0;
    endtask

    task automatic test_single_byte();
        do_reset();
        load(2, 1'b1, 8'hA5);
        drain();
        vectors++;
        if (acc_q.size() != 1 || st_q.size() != 1) begin
            errors++; $display("FAIL single_count: accepts %0d starts %0d, want 1 1", acc_q.size(), st_q.size());
        end else begin
            vectors++;
            if (acc_q[0].r != 2 || acc_q[0].d !== 8'hA5) begin
                errors++; $display("FAIL single_accept: req %0d data %h, want 2 a5", acc_q[0].r, acc_q[0].d);
            end
            vectors++;
            if (st_q[0].c != acc_q[0].c + 1 || st_q[0].d !== 8'hA5 || st_q[0].g !== 4'b0100) begin
                errors++; $display("FAIL single_start: cycle %0d data %h grant %b, want %0d a5 0100", st_q[0].c, st_q[0].d, st_q[0].g, acc_q[0].c + 1);
            end
        end
        vectors++; if (grant !== 4'b0) begin errors++; $display("FAIL single_grant_idle: got %b, want 0000", grant); end
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int i = 0; i < 4; i++) load(i, 1'b1, 8'h10 + 8'(i));
        load(0, 1'b1, 8'h14);
        build_expect();
        drain();
        vectors++;
        if (acc_q.size() != exp_q.size()) begin
            errors++; $display("FAIL rr_count: got %0d, want %0d", acc_q.size(), exp_q.size());
        end
        for (int k = 0; k < acc_q.size() && k < exp_q.size(); k++) begin
            vectors++;
            if (acc_q[k].r != exp_q[k].r || acc_q[k].d !== exp_q[k].d) begin
                errors++; $display("FAIL rr_order[%0d]: req %0d data %h, want req %0d data %h", k, acc_q[k].r, acc_q[k].d, exp_q[k].r, exp_q[k].d);
            end
        end
        vectors++; if (overlap_n != 0) begin errors++; $display("FAIL rr_overlap: %0d starts while in flight, want 0", overlap_n); end
    endtask

    task automatic test_frame_lock();
        do_reset();
        load(0, 1'b1, 8'h55);
        load(0, 1'b1, 8'h56);
        load(1, 1'b0, 8'hC0);
        load(1, 1'b0, 8'hC1);
        load(1, 1'b1, 8'hC2);
        build_expect();
        drain();
        vectors++;
        if (acc_q.size() != 5) begin
            errors++; $display("FAIL lock_count: got %0d, want 5", acc_q.size());
        end
        for (int k = 0; k < acc_q.size() && k < exp_q.size(); k++) begin
            vectors++;
            if (acc_q[k].r != exp_q[k].r || acc_q[k].d !== exp_q[k].d) begin
                errors++; $display("FAIL lock_order[%0d]: req %0d data %h, want req %0d data %h", k, acc_q[k].r, acc_q[k].d, exp_q[k].r, exp_q[k].d);
            end
        end
    endtask

    task automatic test_gap();
        do_reset();
        load(3, 1'b1, 8'h21);
        load(3, 1'b1, 8'h22);
        drain();
        vectors++;
        if (acc_q.size() != 2 || done_q.size() < 1) begin
            errors++; $display("FAIL gap_count: accepts %0d dones %0d, want 2 and >=1", acc_q.size(), done_q.size());
        end else begin
            vectors++;
            if (acc_q[1].c != done_q[0] + 6) begin
                errors++; $display("FAIL gap_timing: second accept at %0d, want %0d", acc_q[1].c, done_q[0] + 6);
            end
        end
    endtask

    task automatic test_lock_timeout();
        int         n;
        logic [3:0] g_before;
        do_reset();
        load(3, 1'b0, 8'h77);
        n = 0;
        while (acc_q.size() == 0 && n < 50) begin cycle(); n++; end
        load(0, 1'b1, 8'h0A);
        g_before = 4'b0;
        n = 0;
        while (abort_q.size() == 0 && n < 300) begin
            cycle(); n++;
            if (abort_q.size() == 0) g_before = grant;
        end
        vectors++;
        if (abort_q.size() != 1 || done_q.size() != 1) begin
            errors++; $display("FAIL tmo_seen: aborts %0d dones %0d, want 1 1", abort_q.size(), done_q.size());
        end else begin
            vectors++;
            if (abort_q[0] != done_q[0] + 1 + GAP + TMO) begin
                errors++; $display("FAIL tmo_timing: abort at %0d, want %0d", abort_q[0], done_q[0] + 1 + GAP + TMO);
            end
            vectors++; if (abort_grant !== 4'b0) begin errors++; $display("FAIL tmo_grant: got %b, want 0000", abort_grant); end
            vectors++; if (g_before !== 4'b1000) begin errors++; $display("FAIL tmo_hold_grant: got %b, want 1000", g_before); end
        end
        drain();
        vectors++;
        if (acc_q.size() != 2 || abort_q.size() != 1) begin
            errors++; $display("FAIL tmo_after: accepts %0d aborts %0d, want 2 1", acc_q.size(), abort_q.size());
        end else begin
            vectors++;
            if (acc_q[1].r != 0 || acc_q[1].d !== 8'h0A || acc_q[1].c < abort_q[0]) begin
                errors++; $display("FAIL tmo_next: req %0d data %h cycle %0d, want req 0 data 0a at >=%0d", acc_q[1].r, acc_q[1].d, acc_q[1].c, abort_q[0]);
            end
        end
    endtask

    task automatic test_mid_reset();
        int n = 0;
        do_reset();
        load(1, 1'b1, 8'h3C);
        while (st_q.size() == 0 && n < 50) begin cycle(); n++; end
        cycle();
        vectors++; if (busy !== 1'b1) begin errors++; $display("FAIL mrst_busy_wait: got %b, want 1", busy); end
        reset  = 1'b1;
        tx_act = 1'b0;
        cycle();
        vectors++;
        if (req_ready !== 4'b0 || tx_start !== 1'b0 || tx_data !== 8'h00 || grant !== 4'b0 || busy !== 1'b0 || lock_abort !== 1'b0) begin
            errors++;
            $display("FAIL mrst_outputs: ready %b start %b data %h grant %b busy %b abort %b, want all zero", req_ready, tx_start, tx_data, grant, busy, lock_abort);
        end
        reset = 1'b0;
        clear_log();
        load(2, 1'b1, 8'h5A);
        drain();
        vectors++;
        if (st_q.size() != 1 || acc_q.size() != 1) begin
            errors++; $display("FAIL mrst_count: starts %0d accepts %0d, want 1 1", st_q.size(), acc_q.size());
        end else begin
            vectors++;
            if (st_q[0].d !== 8'h5A || st_q[0].g !== 4'b0100 || st_q[0].c != acc_q[0].c + 1) begin
                errors++; $display("FAIL mrst_resume: data %h grant %b, want 5a 0100", st_q[0].d, st_q[0].g);
            end
        end
    endtask

    task automatic test_random();
        int nf, len;
        for (int it = 0; it < 4; it++) begin
            do_reset();
            for (int r = 0; r < 4; r++) begin
                nf = $urandom_range(0, 3);
                for (int f = 0; f < nf; f++) begin
                    len = $urandom_range(1, 3);
                    for (int b = 0; b < len; b++) load(r, (b == len - 1), 8'($urandom));
                end
            end
            build_expect();
            drain();
            vectors++;
            if (acc_q.size() != exp_q.size() || st_q.size() != acc_q.size()) begin
                errors++; $display("FAIL rnd_count[%0d]: accepts %0d starts %0d, want %0d", it, acc_q.size(), st_q.size(), exp_q.size());
            end
            for (int k = 0; k < acc_q.size() && k < exp_q.size() && k < st_q.size(); k++) begin
                vectors++;
                if (acc_q[k].r != exp_q[k].r || acc_q[k].d !== exp_q[k].d) begin
                    errors++; $display("FAIL rnd_order[%0d.%0d]: req %0d data %h, want req %0d data %h", it, k, acc_q[k].r, acc_q[k].d, exp_q[k].r, exp_q[k].d);
                end
                vectors++;
                if (st_q[k].c != acc_q[k].c + 1 || st_q[k].d !== acc_q[k].d || st_q[k].g !== 4'(1 << acc_q[k].r)) begin
                    errors++; $display("FAIL rnd_start[%0d.%0d]: cycle %0d data %h grant %b, want %0d %h onehot %0d", it, k, st_q[k].c, st_q[k].d, st_q[k].g, acc_q[k].c + 1, acc_q[k].d, acc_q[k].r);
                end
                if (k > 0 && k <= done_q.size()) begin
                    vectors++;
                    if (acc_q[k].c != done_q[k-1] + 1 + GAP) begin
                        errors++; $display("FAIL rnd_gap[%0d.%0d]: accept at %0d, want %0d", it, k, acc_q[k].c, done_q[k-1] + 1 + GAP);
                    end
                end
            end
            vectors++;
            if (overlap_n != 0 || unstable_n != 0 || badrdy_n != 0) begin
                errors++; $display("FAIL rnd_protocol[%0d]: overlap %0d unstable %0d badready %0d, want 0 0 0", it, overlap_n, unstable_n, badrdy_n);
            end
        end
    endtask

    initial begin
        cyc = 0; vectors = 0; errors = 0;
        tx_act = 1'b0; tx_cnt = 0; tx_hold = 8'h00; abort_grant = 4'b0;
        clear_log();
        test_reset();
        test_single_byte();
        test_round_robin();
        test_frame_lock();
        test_gap();
        test_lock_timeout();
        test_mid_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
